// File: rtl/pix_line_fetcher_if.sv
// PIXREQ (request FIFO write side) and PIXANS (answer FIFO read side) bundle.
// master = line fetcher, slave = FIFO/controller side.
interface pix_line_fetcher_if;
   logic [35:0]  PIXREQ_data;
   logic         PIXREQ_wrreq;
   logic         PIXREQ_wrfull;
   logic [135:0] PIXANS_q;
   logic         PIXANS_rdreq;
   logic         PIXANS_rdempty;

   modport master (
      output PIXREQ_data,
      output PIXREQ_wrreq,
      input  PIXREQ_wrfull,
      input  PIXANS_q,
      output PIXANS_rdreq,
      input  PIXANS_rdempty
   );

   modport slave (
      input  PIXREQ_data,
      input  PIXREQ_wrreq,
      output PIXREQ_wrfull,
      output PIXANS_q,
      input  PIXANS_rdreq,
      output PIXANS_rdempty
   );
endinterface

// File: rtl/pix_line_fetcher.sv
// Line fetcher: issues WordCount word requests starting at BaseAddr into the
// PIXREQ FIFO, pops tagged answers from PIXANS and streams them to the line
// buffer, flagging any answer whose tag does not match its word index.
module pix_line_fetcher #(
   parameter int unsigned MAX_OUT = 4
) (
   input  logic               MemClk,
   input  logic               Reset,
   input  logic               ScreenStop,
   input  logic               Start,
   input  logic [18:0]        BaseAddr,
   input  logic [7:0]         WordCount,
   output logic               Busy,
   output logic               Done,
   output logic               TagError,
   pix_line_fetcher_if.master pix,
   output logic               LB_we,
   output logic [7:0]         LB_addr,
   output logic [127:0]       LB_data
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t       state;
   logic [8:0]   req_idx;
   logic [8:0]   pop_idx;
   logic [8:0]   wr_idx;
   logic [7:0]   word_cnt;
   logic [18:0]  req_addr;
   logic [35:0]  req_data;
   logic         pop_d;
   logic         done_zero;
   logic         tag_err;

   logic         abort;
   logic         run;
   logic [8:0]   in_flight;
   logic         push;
   logic         pop;
   logic         wb;
   logic         last_wb;

   // Issue/pop/writeback decisions; strobes depend on the FIFO flags of the
   // current cycle, so they are gated combinationally rather than registered.
   always_comb begin
      abort     = Reset | ScreenStop;
      run       = (state == RUN) && !abort;
      in_flight = req_idx - pop_idx;
      push      = run && (req_idx < {1'b0, word_cnt}) && !pix.PIXREQ_wrfull
                  && (in_flight < 9'(MAX_OUT));
      pop       = run && !pix.PIXANS_rdempty && (pop_idx < req_idx);
      wb        = pop_d && !abort;
      last_wb   = wb && ((wr_idx + 9'd1) == {1'b0, word_cnt});
   end

   assign pix.PIXREQ_data  = req_data;
   assign pix.PIXREQ_wrreq = push;
   assign pix.PIXANS_rdreq = pop;
   assign LB_we            = wb;
   assign LB_addr          = wr_idx[7:0];
   assign LB_data          = pix.PIXANS_q[127:0];
   assign Busy             = (state != IDLE);
   assign Done             = (done_zero && !abort) || last_wb;
   assign TagError         = tag_err;

   // Fetch FSM with its counters; req_data always holds the request for
   // req_idx so a push can present it without an extra cycle.
   always_ff @(posedge MemClk) begin
      if (abort) begin
         state     <= IDLE;
         req_idx   <= '0;
         pop_idx   <= '0;
         wr_idx    <= '0;
         word_cnt  <= '0;
         req_addr  <= '0;
         req_data  <= '0;
         pop_d     <= 1'b0;
         done_zero <= 1'b0;
         if (Reset) begin
            tag_err <= 1'b0;
         end
      end else begin
         pop_d     <= pop;
         done_zero <= 1'b0;
         case (state)
            IDLE: begin
               if (Start) begin
                  tag_err  <= 1'b0;
                  word_cnt <= WordCount;
                  req_idx  <= '0;
                  pop_idx  <= '0;
                  wr_idx   <= '0;
                  req_addr <= BaseAddr;
                  req_data <= {9'b0, 8'h00, BaseAddr};
                  if (WordCount == 8'd0) begin
                     done_zero <= 1'b1;
                  end else begin
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               if (push) begin
                  req_idx  <= req_idx + 9'd1;
                  req_addr <= req_addr + 19'd1;
                  req_data <= {9'b0, req_idx[7:0] + 8'd1, req_addr + 19'd1};
               end
               if (pop) begin
                  pop_idx <= pop_idx + 9'd1;
               end
               if (wb) begin
                  wr_idx <= wr_idx + 9'd1;
                  if (pix.PIXANS_q[135:128] != wr_idx[7:0]) begin
                     tag_err <= 1'b1;
                  end
               end
               if (last_wb) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pix_line_fetcher.sv
// Bench for pix_line_fetcher: ideal FIFO/memory model plus a scoreboard of
// expected requests and line-buffer writes, driven by per-scenario tasks.
module tb_pix_line_fetcher;

   logic         MemClk = 1'b0;
   logic         Reset;
   logic         ScreenStop;
   logic         Start;
   logic [18:0]  BaseAddr;
   logic [7:0]   WordCount;
   logic         Busy;
   logic         Done;
   logic         TagError;
   logic         LB_we;
   logic [7:0]   LB_addr;
   logic [127:0] LB_data;
   logic         force_full;

   pix_line_fetcher_if pif ();

   pix_line_fetcher #(.MAX_OUT(4)) dut (
      .MemClk     (MemClk),
      .Reset      (Reset),
      .ScreenStop (ScreenStop),
      .Start      (Start),
      .BaseAddr   (BaseAddr),
      .WordCount  (WordCount),
      .Busy       (Busy),
      .Done       (Done),
      .TagError   (TagError),
      .pix        (pif),
      .LB_we      (LB_we),
      .LB_addr    (LB_addr),
      .LB_data    (LB_data)
   );

   always #5 MemClk = ~MemClk;

   assign pif.PIXREQ_wrfull = force_full;

   int           vectors     = 0;
   int           miscompares = 0;
   int           lb_cnt      = 0;
   int           req_cnt     = 0;
   int           pop_cnt     = 0;
   int           done_cnt    = 0;
   int           corrupt_tag = -1;
   int           release_cnt = 0;
   bit           hold        = 1'b0;
   logic [35:0]  exp_req[$];
   logic [135:0] exp_lb[$];
   logic [135:0] pending[$];
   logic [135:0] ans_q[$];

   // Memory contents seen by the fetcher.
   function automatic logic [127:0] mem_word(input logic [18:0] a);
      return {13'h1A5A, a, 13'h0C3C, ~a, 32'hDEAD0000 | {13'b0, a}, 32'(a) * 32'd2654435761};
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge MemClk);
         #2;
      end
   endtask

   // Ideal request FIFO + memory + normal-mode answer FIFO.
   task automatic fifo_model;
      logic        got_req, got_full, got_pop;
      logic [35:0] rd;
      logic [7:0]  t;
      forever begin
         @(posedge MemClk);
         got_req  = pif.PIXREQ_wrreq;
         got_full = pif.PIXREQ_wrfull;
         got_pop  = pif.PIXANS_rdreq;
         rd       = pif.PIXREQ_data;
         #1;
         if (got_req && !got_full) begin
            t = rd[26:19];
            if (corrupt_tag >= 0 && int'(t) == corrupt_tag) t = t + 8'd1;
            pending.push_back({t, mem_word(rd[18:0])});
         end
         if (got_pop && ans_q.size() > 0) pif.PIXANS_q = ans_q.pop_front();
         if (pending.size() > 0 && (!hold || release_cnt > 0)) begin
            ans_q.push_back(pending.pop_front());
            if (hold) release_cnt--;
         end
         pif.PIXANS_rdempty = (ans_q.size() == 0);
      end
   endtask

   // Pops expected requests / line-buffer writes as the DUT produces them.
   task automatic scoreboard;
      logic [135:0] e;
      logic [35:0]  r;
      forever begin
         @(negedge MemClk);
         if (LB_we) begin
            lb_cnt++;
            vectors++;
            if (exp_lb.size() == 0) begin
               miscompares++;
               $display("FAIL lb_unexpected: got addr=%0d data=%h, expected no write", LB_addr, LB_data);
            end else begin
               e = exp_lb.pop_front();
               if ({LB_addr, LB_data} !== e) begin
                  miscompares++;
                  $display("FAIL lb_write: got addr=%0d data=%h, expected addr=%0d data=%h",
                           LB_addr, LB_data, e[135:128], e[127:0]);
               end
            end
         end
         if (pif.PIXREQ_wrreq) begin
            req_cnt++;
            vectors++;
            if (pif.PIXREQ_wrfull !== 1'b0) begin
               miscompares++;
               $display("FAIL push_while_full: got wrfull=%b at push, expected 0", pif.PIXREQ_wrfull);
            end else if (exp_req.size() == 0) begin
               miscompares++;
               $display("FAIL req_unexpected: got %h, expected no request", pif.PIXREQ_data);
            end else begin
               r = exp_req.pop_front();
               if (pif.PIXREQ_data !== r) begin
                  miscompares++;
                  $display("FAIL req_data: got %h expected %h", pif.PIXREQ_data, r);
               end
            end
         end
         if (pif.PIXANS_rdreq) begin
            pop_cnt++;
            vectors++;
            if (pif.PIXANS_rdempty !== 1'b0) begin
               miscompares++;
               $display("FAIL pop_while_empty: got rdempty=%b expected 0", pif.PIXANS_rdempty);
            end
         end
         if (Done) done_cnt++;
      end
   endtask

   task automatic pulse_start(input logic [18:0] base, input logic [7:0] cnt);
      BaseAddr  = base;
      WordCount = cnt;
      Start     = 1'b1;
      tick(1);
      Start     = 1'b0;
      BaseAddr  = 19'($urandom);
      WordCount = 8'($urandom);
   endtask

   task automatic start_fetch(input logic [18:0] base, input int cnt);
      for (int i = 0; i < cnt; i++) begin
         logic [18:0] a;
         a = base + 19'(i);
         exp_req.push_back({9'b0, 8'(i), a});
         exp_lb.push_back({8'(i), mem_word(a)});
      end
      pulse_start(base, 8'(cnt));
   endtask

   task automatic wait_done(input int bound, output bit ok);
      int d0;
      d0 = done_cnt;
      ok = 1'b0;
      for (int i = 0; i < bound && !ok; i++) begin
         tick(1);
         if (done_cnt != d0) ok = 1'b1;
      end
   endtask

   task automatic test_reset;
      Reset = 1'b1;
      tick(3);
      vectors += 7;
      if (Busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", Busy); end
      if (Done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", Done); end
      if (TagError !== 1'b0) begin miscompares++; $display("FAIL reset_tagerr: got %b expected 0", TagError); end
      if (pif.PIXREQ_wrreq !== 1'b0) begin miscompares++; $display("FAIL reset_wrreq: got %b expected 0", pif.PIXREQ_wrreq); end
      if (pif.PIXANS_rdreq !== 1'b0) begin miscompares++; $display("FAIL reset_rdreq: got %b expected 0", pif.PIXANS_rdreq); end
      if (LB_we !== 1'b0) begin miscompares++; $display("FAIL reset_lbwe: got %b expected 0", LB_we); end
      if (pif.PIXREQ_data !== 36'h0) begin miscompares++; $display("FAIL reset_reqdata: got %h expected 0", pif.PIXREQ_data); end
      Reset = 1'b0;
      tick(2);
      vectors += 2;
      if (Busy !== 1'b0) begin miscompares++; $display("FAIL idle_busy: got %b expected 0", Busy); end
      if (pif.PIXREQ_data !== 36'h0) begin miscompares++; $display("FAIL idle_reqdata: got %h expected 0", pif.PIXREQ_data); end
   endtask

   task automatic test_zero_count;
      int r0;
      r0 = req_cnt;
      pulse_start(19'h55, 8'd0);
      vectors += 2;
      if (Done !== 1'b1) begin miscompares++; $display("FAIL zero_done: got %b expected 1", Done); end
      if (Busy !== 1'b0) begin miscompares++; $display("FAIL zero_busy: got %b expected 0", Busy); end
      tick(2);
      vectors += 2;
      if (Done !== 1'b0) begin miscompares++; $display("FAIL zero_done_width: got %b expected 0", Done); end
      if (req_cnt != r0) begin miscompares++; $display("FAIL zero_reqs: got %0d expected 0", req_cnt - r0); end
   endtask

   task automatic test_basic;
      int l0, d0;
      bit ok;
      l0 = lb_cnt;
      d0 = done_cnt;
      exp_req.push_back(36'h000000100);
      exp_req.push_back(36'h000080101);
      exp_req.push_back(36'h000100102);
      exp_lb.push_back({8'd0, mem_word(19'h00100)});
      exp_lb.push_back({8'd1, mem_word(19'h00101)});
      exp_lb.push_back({8'd2, mem_word(19'h00102)});
      pulse_start(19'h100, 8'd3);
      vectors++;
      if (Busy !== 1'b1) begin miscompares++; $display("FAIL basic_busy: got %b expected 1", Busy); end
      wait_done(60, ok);
      vectors += 3;
      if (!ok) begin miscompares++; $display("FAIL basic_timeout: got no Done, expected Done within 60 cycles"); end
      if (Busy !== 1'b0) begin miscompares++; $display("FAIL basic_busy_after: got %b expected 0", Busy); end
      if (Done !== 1'b0) begin miscompares++; $display("FAIL basic_done_width: got %b expected 0", Done); end
      tick(3);
      vectors += 4;
      if (lb_cnt - l0 != 3) begin miscompares++; $display("FAIL basic_lb_count: got %0d expected 3", lb_cnt - l0); end
      if (done_cnt - d0 != 1) begin miscompares++; $display("FAIL basic_done_count: got %0d expected 1", done_cnt - d0); end
      if (exp_req.size() + exp_lb.size() != 0) begin miscompares++; $display("FAIL basic_leftover: got %0d expected 0", exp_req.size() + exp_lb.size()); end
      if (TagError !== 1'b0) begin miscompares++; $display("FAIL basic_tagerr: got %b expected 0", TagError); end
   endtask

   task automatic test_wrap;
      int l0;
      bit ok;
      l0 = lb_cnt;
      start_fetch(19'h7FFFE, 4);
      wait_done(80, ok);
      vectors += 4;
      if (!ok) begin miscompares++; $display("FAIL wrap_timeout: got no Done, expected Done"); end
      if (TagError !== 1'b0) begin miscompares++; $display("FAIL wrap_tagerr: got %b expected 0", TagError); end
      if (lb_cnt - l0 != 4) begin miscompares++; $display("FAIL wrap_lb_count: got %0d expected 4", lb_cnt - l0); end
      if (exp_req.size() + exp_lb.size() != 0) begin miscompares++; $display("FAIL wrap_leftover: got %0d expected 0", exp_req.size() + exp_lb.size()); end
   endtask

   task automatic test_max_out;
      int r0, l0;
      bit ok;
      r0 = req_cnt;
      l0 = lb_cnt;
      hold = 1'b1;
      release_cnt = 0;
      start_fetch(19'h1000, 10);
      tick(12);
      vectors += 2;
      if (req_cnt - r0 != 4) begin miscompares++; $display("FAIL maxout_pushes: got %0d expected 4", req_cnt - r0); end
      if (pif.PIXREQ_wrreq !== 1'b0) begin miscompares++; $display("FAIL maxout_wrreq: got %b expected 0", pif.PIXREQ_wrreq); end
      release_cnt = 1;
      tick(8);
      vectors++;
      if (req_cnt - r0 != 5) begin miscompares++; $display("FAIL maxout_resume: got %0d expected 5", req_cnt - r0); end
      hold = 1'b0;
      wait_done(200, ok);
      vectors += 3;
      if (!ok) begin miscompares++; $display("FAIL maxout_timeout: got no Done, expected Done"); end
      if (lb_cnt - l0 != 10) begin miscompares++; $display("FAIL maxout_lb_count: got %0d expected 10", lb_cnt - l0); end
      if (exp_req.size() + exp_lb.size() != 0) begin miscompares++; $display("FAIL maxout_leftover: got %0d expected 0", exp_req.size() + exp_lb.size()); end
   endtask

   task automatic test_wrfull;
      int r0, r1, l0;
      bit ok;
      l0 = lb_cnt;
      start_fetch(19'h2000, 8);
      tick(1);
      force_full = 1'b1;
      r0 = req_cnt;
      tick(5);
      r1 = req_cnt;
      vectors += 2;
      if (r1 != r0) begin miscompares++; $display("FAIL full_pushes: got %0d expected 0", r1 - r0); end
      if (pif.PIXREQ_wrreq !== 1'b0) begin miscompares++; $display("FAIL full_wrreq: got %b expected 0", pif.PIXREQ_wrreq); end
      force_full = 1'b0;
      wait_done(150, ok);
      vectors += 4;
      if (!ok) begin miscompares++; $display("FAIL full_timeout: got no Done, expected Done"); end
      if (lb_cnt - l0 != 8) begin miscompares++; $display("FAIL full_lb_count: got %0d expected 8", lb_cnt - l0); end
      if (exp_req.size() + exp_lb.size() != 0) begin miscompares++; $display("FAIL full_leftover: got %0d expected 0", exp_req.size() + exp_lb.size()); end
      if (TagError !== 1'b0) begin miscompares++; $display("FAIL full_tagerr: got %b expected 0", TagError); end
   endtask

   task automatic test_tag_error;
      int l0, d0;
      bit ok;
      l0 = lb_cnt;
      d0 = done_cnt;
      corrupt_tag = 4;
      start_fetch(19'h3000, 8);
      wait_done(150, ok);
      vectors += 5;
      if (!ok) begin miscompares++; $display("FAIL tag_timeout: got no Done, expected Done"); end
      if (TagError !== 1'b1) begin miscompares++; $display("FAIL tag_set: got %b expected 1", TagError); end
      if (lb_cnt - l0 != 8) begin miscompares++; $display("FAIL tag_lb_count: got %0d expected 8", lb_cnt - l0); end
      if (done_cnt - d0 != 1) begin miscompares++; $display("FAIL tag_done_count: got %0d expected 1", done_cnt - d0); end
      if (exp_lb.size() != 0) begin miscompares++; $display("FAIL tag_leftover: got %0d expected 0", exp_lb.size()); end
      corrupt_tag = -1;
      start_fetch(19'h3100, 2);
      vectors++;
      if (TagError !== 1'b0) begin miscompares++; $display("FAIL tag_clear: got %b expected 0", TagError); end
      wait_done(60, ok);
      vectors += 2;
      if (!ok) begin miscompares++; $display("FAIL tag2_timeout: got no Done, expected Done"); end
      if (TagError !== 1'b0) begin miscompares++; $display("FAIL tag2_clean: got %b expected 0", TagError); end
   endtask

   task automatic test_abort(input bit use_reset);
      int l0, l1, r1, d1, p1;
      bit ok;
      logic exp_te;
      l0 = lb_cnt;
      corrupt_tag = 2;
      start_fetch(19'h0, 20);
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         tick(1);
         if (lb_cnt - l0 >= 6) ok = 1'b1;
      end
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL abort_wait: got %0d words, expected 6", lb_cnt - l0); end
      if (use_reset) Reset = 1'b1;
      else ScreenStop = 1'b1;
      exp_te = use_reset ? 1'b0 : 1'b1;
      l1 = lb_cnt;
      r1 = req_cnt;
      d1 = done_cnt;
      tick(1);
      Reset = 1'b0;
      ScreenStop = 1'b0;
      exp_req.delete();
      exp_lb.delete();
      pending.delete();
      ans_q.delete();
      corrupt_tag = -1;
      // stray answer while idle must never be popped
      ans_q.push_back({8'h00, mem_word(19'h0)});
      pif.PIXANS_rdempty = 1'b0;
      p1 = pop_cnt;
      vectors += 2;
      if (Busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got %b expected 0", Busy); end
      if (TagError !== exp_te) begin miscompares++; $display("FAIL abort_tagerr: got %b expected %b", TagError, exp_te); end
      tick(10);
      vectors += 4;
      if (lb_cnt != l1) begin miscompares++; $display("FAIL abort_lb: got %0d extra writes expected 0", lb_cnt - l1); end
      if (req_cnt != r1) begin miscompares++; $display("FAIL abort_req: got %0d extra pushes expected 0", req_cnt - r1); end
      if (done_cnt != d1) begin miscompares++; $display("FAIL abort_done: got %0d Done pulses expected 0", done_cnt - d1); end
      if (pop_cnt != p1) begin miscompares++; $display("FAIL abort_stray_pop: got %0d pops expected 0", pop_cnt - p1); end
      ans_q.delete();
      pif.PIXANS_rdempty = 1'b1;
      tick(1);
      l0 = lb_cnt;
      start_fetch(19'h40, 3);
      wait_done(60, ok);
      vectors += 3;
      if (!ok) begin miscompares++; $display("FAIL restart_timeout: got no Done, expected Done"); end
      if (lb_cnt - l0 != 3) begin miscompares++; $display("FAIL restart_lb_count: got %0d expected 3", lb_cnt - l0); end
      if (exp_req.size() + exp_lb.size() != 0) begin miscompares++; $display("FAIL restart_leftover: got %0d expected 0", exp_req.size() + exp_lb.size()); end
   endtask

   initial begin
      Reset              = 1'b1;
      ScreenStop         = 1'b0;
      Start              = 1'b0;
      BaseAddr           = '0;
      WordCount          = '0;
      force_full         = 1'b0;
      pif.PIXANS_q       = '0;
      pif.PIXANS_rdempty = 1'b1;
      fork
         fifo_model();
         scoreboard();
         begin
            #500000;
            $display("FAIL watchdog: got no end of run, expected finish before 500000");
            $fatal(1);
         end
      join_none
      test_reset();
      test_zero_count();
      test_basic();
      test_wrap();
      test_max_out();
      test_wrfull();
      test_tag_error();
      test_abort(1'b0);
      test_abort(1'b1);
      tick(2);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
